// File: rtl/lc3b_dm_cache.sv
// Direct-mapped, write-back, write-allocate cache between the LC-3b CPU and a
// line-wide physical memory. Hits complete combinationally in IDLE.
module lc3b_dm_cache #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [15:0]                       mem_address,
    input  logic [15:0]                       mem_wdata,
    input  logic [1:0]                        mem_byte_enable,
    output logic [15:0]                       mem_rdata,
    output logic                              mem_resp,
    output logic                              pmem_read,
    output logic                              pmem_write,
    output logic [15:0]                       pmem_address,
    output logic [16*(2**OFFSET_BITS)-1:0]    pmem_wdata,
    input  logic [16*(2**OFFSET_BITS)-1:0]    pmem_rdata,
    input  logic                              pmem_resp,
    output logic [15:0]                       hit_count,
    output logic [15:0]                       miss_count,
    output logic [1:0]                        state_dbg
);

    localparam int TAG_BITS  = 15 - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_BITS = 16 * (2**OFFSET_BITS);
    localparam int SETS      = 2**INDEX_BITS;

    // Handshake: the CPU holds mem_read/mem_write and its operands until the
    // cycle mem_resp is high; the cache holds pmem_read/pmem_write and the
    // line address until the cycle pmem_resp is high. A strobe together with
    // its response completes the transfer on that rising edge.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t                 state;
    logic                   retry;
    logic [TAG_BITS-1:0]    tag_arr  [SETS];
    logic [LINE_BITS-1:0]   data_arr [SETS];
    logic [SETS-1:0]        valid_arr;
    logic [SETS-1:0]        dirty_arr;

    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_index;
    logic [OFFSET_BITS-1:0] req_word;
    logic                   req_active;
    logic                   hit;
    logic                   idle_hit;
    logic [LINE_BITS-1:0]   line_cur;
    logic [LINE_BITS-1:0]   line_merged;
    logic [15:0]            old_word;
    logic [15:0]            new_word;

    assign req_tag    = mem_address[15 -: TAG_BITS];
    assign req_index  = mem_address[OFFSET_BITS+1 +: INDEX_BITS];
    assign req_word   = mem_address[1 +: OFFSET_BITS];
    assign req_active = mem_read | mem_write;
    assign hit        = valid_arr[req_index] && (tag_arr[req_index] == req_tag);
    assign idle_hit   = (state == IDLE) && req_active && hit;

    assign line_cur   = data_arr[req_index];
    assign old_word   = line_cur[{req_word, 4'b0000} +: 16];
    assign new_word   = {mem_byte_enable[1] ? mem_wdata[15:8] : old_word[15:8],
                         mem_byte_enable[0] ? mem_wdata[7:0]  : old_word[7:0]};

    always_comb begin
        line_merged = line_cur;
        line_merged[{req_word, 4'b0000} +: 16] = new_word;
    end

    assign mem_resp   = idle_hit;
    assign mem_rdata  = old_word;
    assign pmem_wdata = line_cur;
    assign state_dbg  = state;

    // Tag and data arrays carry no reset; valid_arr gates every use of them.
    always_ff @(posedge clk) begin
        if (idle_hit && mem_write) begin
            data_arr[req_index] <= line_merged;
        end else if (state == FILL && pmem_resp) begin
            data_arr[req_index] <= pmem_rdata;
            tag_arr[req_index]  <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            retry        <= 1'b0;
            valid_arr    <= '0;
            dirty_arr    <= '0;
            hit_count    <= 16'h0000;
            miss_count   <= 16'h0000;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_active) begin
                        if (hit) begin
                            if (mem_write) dirty_arr[req_index] <= 1'b1;
                            // The post-fill hit finishes a request already counted as a miss.
                            if (!retry && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                            retry <= 1'b0;
                        end else begin
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                            if (valid_arr[req_index] && dirty_arr[req_index]) begin
                                state        <= WRITEBACK;
                                pmem_write   <= 1'b1;
                                pmem_address <= {tag_arr[req_index], req_index, {(OFFSET_BITS+1){1'b0}}};
                            end else begin
                                state        <= FILL;
                                pmem_read    <= 1'b1;
                                pmem_address <= {req_tag, req_index, {(OFFSET_BITS+1){1'b0}}};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state        <= FILL;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_index, {(OFFSET_BITS+1){1'b0}}};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state                <= IDLE;
                        pmem_read            <= 1'b0;
                        valid_arr[req_index] <= 1'b1;
                        dirty_arr[req_index] <= 1'b0;
                        retry                <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_dm_cache.sv
// Directed bench for lc3b_dm_cache: default geometry plus a 4/2 geometry
// instance, with a bench-side memory responder.
module tb_lc3b_dm_cache;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0]  mem_address = '0, mem_wdata = '0;
    logic [1:0]   mem_byte_enable = '0;
    logic [15:0]  mem_rdata;
    logic         mem_resp, pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [15:0]  hit_count, miss_count;
    logic [1:0]   state_dbg;

    logic         s_mem_read = 1'b0, s_mem_write = 1'b0;
    logic [15:0]  s_mem_address = '0, s_mem_wdata = '0;
    logic [1:0]   s_mem_byte_enable = '0;
    logic [15:0]  s_mem_rdata;
    logic         s_mem_resp, s_pmem_read, s_pmem_write;
    logic [15:0]  s_pmem_address;
    logic [63:0]  s_pmem_wdata;
    logic [63:0]  s_pmem_rdata = '0;
    logic         s_pmem_resp = 1'b0;
    logic [15:0]  s_hit_count, s_miss_count;
    logic [1:0]   s_state_dbg;

    int checks = 0;
    int errors = 0;
    bit overlap_seen = 1'b0;
    logic [127:0] line1, line2, exp_victim;

    always #5 clk = ~clk;

    always @(negedge clk) if (pmem_read && pmem_write) overlap_seen = 1'b1;

    lc3b_dm_cache dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
    );

    lc3b_dm_cache #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut_s (
        .clk(clk), .reset(reset),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_address(s_mem_address),
        .mem_wdata(s_mem_wdata), .mem_byte_enable(s_mem_byte_enable),
        .mem_rdata(s_mem_rdata), .mem_resp(s_mem_resp),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_address(s_pmem_address),
        .pmem_wdata(s_pmem_wdata), .pmem_rdata(s_pmem_rdata), .pmem_resp(s_pmem_resp),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .state_dbg(s_state_dbg)
    );

    // Memory responder: waits (bounded) for the requested strobe, captures the
    // request, then answers with a one-cycle pmem_resp.
    task automatic serve(input bit want_write, input logic [127:0] line,
                         output logic [15:0] addr, output logic [127:0] wd,
                         output bit timed_out);
        timed_out = 1'b1;
        addr = '0;
        wd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (want_write ? pmem_write : pmem_read) begin
                timed_out = 1'b0;
                addr = pmem_address;
                wd = pmem_wdata;
                break;
            end
        end
        if (!timed_out) begin
            pmem_rdata = line;
            pmem_resp = 1'b1;
            @(negedge clk);
            pmem_resp = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
        checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b exp 0", mem_resp); end
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL reset_pmem got %b exp 00", {pmem_read, pmem_write}); end
        checks++; if (pmem_address !== 16'h0000) begin errors++; $display("FAIL reset_paddr got %h exp 0000", pmem_address); end
        checks++; if ({hit_count, miss_count} !== 32'h0) begin errors++; $display("FAIL reset_counts got %h exp 0", {hit_count, miss_count}); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({state_dbg, mem_resp, pmem_read, pmem_write} !== 5'b0) begin errors++; $display("FAIL idle_no_req got %b exp 00000", {state_dbg, mem_resp, pmem_read, pmem_write}); end
        checks++; if ({hit_count, miss_count} !== 32'h0) begin errors++; $display("FAIL idle_counts got %h exp 0", {hit_count, miss_count}); end
    endtask

    task automatic test_read_miss();
        logic [15:0] a; logic [127:0] w; bit to;
        mem_read = 1'b1; mem_address = 16'h1234;
        #1;
        checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL miss_no_resp got %b exp 0", mem_resp); end
        serve(1'b0, line1, a, w, to);
        checks++; if (to) begin errors++; $display("FAIL fill_timeout got timeout exp pmem_read"); end
        checks++; if (a !== 16'h1230) begin errors++; $display("FAIL fill_addr got %h exp 1230", a); end
        checks++; if (mem_resp !== 1'b1) begin errors++; $display("FAIL fill_resp got %b exp 1", mem_resp); end
        checks++; if (mem_rdata !== 16'hBEEF) begin errors++; $display("FAIL fill_rdata got %h exp beef", mem_rdata); end
        @(negedge clk);
        mem_read = 1'b0;
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL miss_count1 got %0d exp 1", miss_count); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL hit_count0 got %0d exp 0", hit_count); end
    endtask

    task automatic test_write_hit();
        @(negedge clk);
        mem_write = 1'b1; mem_address = 16'h1235; mem_byte_enable = 2'b10; mem_wdata = 16'hAB00;
        #1;
        checks++; if (mem_resp !== 1'b1) begin errors++; $display("FAIL write_hit_resp got %b exp 1", mem_resp); end
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h1234;
        #1;
        checks++; if (mem_rdata !== 16'hABEF) begin errors++; $display("FAIL byte_merge got %h exp abef", mem_rdata); end
        @(negedge clk);
        mem_read = 1'b0;
        checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL hit_count2 got %0d exp 2", hit_count); end
        // Both strobes at once behave as a write.
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h1232; mem_byte_enable = 2'b01; mem_wdata = 16'h00CD;
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        checks++; if (mem_rdata !== 16'h10CD) begin errors++; $display("FAIL both_strobes got %h exp 10cd", mem_rdata); end
        @(negedge clk);
        mem_read = 1'b0;
        checks++; if (hit_count !== 16'd4) begin errors++; $display("FAIL hit_count4 got %0d exp 4", hit_count); end
    endtask

    task automatic test_writeback();
        logic [15:0] a; logic [127:0] w; bit to;
        mem_read = 1'b1; mem_address = 16'h1A34;
        #1;
        checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL wb_no_resp got %b exp 0", mem_resp); end
        serve(1'b1, '0, a, w, to);
        checks++; if (to) begin errors++; $display("FAIL wb_timeout got timeout exp pmem_write"); end
        checks++; if (a !== 16'h1230) begin errors++; $display("FAIL wb_addr got %h exp 1230", a); end
        checks++; if (w !== exp_victim) begin errors++; $display("FAIL wb_data got %h exp %h", w, exp_victim); end
        serve(1'b0, line2, a, w, to);
        checks++; if (to) begin errors++; $display("FAIL wb_fill_timeout got timeout exp pmem_read"); end
        checks++; if (a !== 16'h1A30) begin errors++; $display("FAIL wb_fill_addr got %h exp 1a30", a); end
        checks++; if ({mem_resp, mem_rdata} !== {1'b1, 16'h7777}) begin errors++; $display("FAIL wb_rdata got %b/%h exp 1/7777", mem_resp, mem_rdata); end
        @(negedge clk);
        mem_read = 1'b0;
        checks++; if (overlap_seen !== 1'b0) begin errors++; $display("FAIL pmem_overlap got 1 exp 0"); end
        checks++; if (miss_count !== 16'd2) begin errors++; $display("FAIL miss_count2 got %0d exp 2", miss_count); end
    endtask

    task automatic test_reset_during_fill();
        logic [15:0] a; logic [127:0] w; bit to; bit seen;
        mem_read = 1'b1; mem_address = 16'h1234;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pmem_read) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rf_fill_start got timeout exp pmem_read"); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({pmem_read, state_dbg} !== 3'b000) begin errors++; $display("FAIL rf_async got %b exp 000", {pmem_read, state_dbg}); end
        checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL rf_miss_clear got %0d exp 0", miss_count); end
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_read = 1'b1; mem_address = 16'h1234;
        #1;
        checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL rf_remiss got %b exp 0", mem_resp); end
        serve(1'b0, line1, a, w, to);
        checks++; if (to || a !== 16'h1230) begin errors++; $display("FAIL rf_refill got %h to=%b exp 1230", a, to); end
        checks++; if (mem_rdata !== 16'hBEEF) begin errors++; $display("FAIL rf_rdata got %h exp beef", mem_rdata); end
        @(negedge clk);
        mem_read = 1'b0;
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL rf_miss_count got %0d exp 1", miss_count); end
    endtask

    task automatic test_small_geometry();
        logic [15:0] a; bit to;
        s_mem_read = 1'b1; s_mem_address = 16'h00F6;
        to = 1'b1; a = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_pmem_read) begin to = 1'b0; a = s_pmem_address; break; end
        end
        checks++; if (to || a !== 16'h00F0) begin errors++; $display("FAIL small_addr got %h to=%b exp 00f0", a, to); end
        s_pmem_rdata = 64'hCAFE_2222_1111_0000;
        s_pmem_resp = 1'b1;
        @(negedge clk);
        s_pmem_resp = 1'b0;
        checks++; if ({s_mem_resp, s_mem_rdata} !== {1'b1, 16'hCAFE}) begin errors++; $display("FAIL small_rdata got %b/%h exp 1/cafe", s_mem_resp, s_mem_rdata); end
        @(negedge clk);
        s_mem_read = 1'b0;
    endtask

    task automatic test_miss_saturation();
        logic [15:0] a; logic [127:0] w; bit to;
        force dut.miss_count = 16'hFFFF;
        @(negedge clk);
        release dut.miss_count;
        @(negedge clk);
        mem_read = 1'b1; mem_address = 16'h0040;
        serve(1'b0, line2, a, w, to);
        checks++; if (to || a !== 16'h0040) begin errors++; $display("FAIL sat_fill got %h to=%b exp 0040", a, to); end
        @(negedge clk);
        mem_read = 1'b0;
        checks++; if (miss_count !== 16'hFFFF) begin errors++; $display("FAIL miss_saturate got %h exp ffff", miss_count); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) line1[i*16 +: 16] = 16'h1000 + 16'(i);
        line1[47:32] = 16'hBEEF;
        line2 = '0;
        line2[47:32] = 16'h7777;
        exp_victim = line1;
        exp_victim[47:32] = 16'hABEF;
        exp_victim[31:16] = 16'h10CD;

        test_reset();
        test_read_miss();
        test_write_hit();
        test_writeback();
        test_reset_during_fill();
        test_small_geometry();
        test_miss_saturation();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_dm_cache.md
LC3B_DM_CACHE -- requirements
Module: lc3b_dm_cache

Interface
REQ-001 Parameter INDEX_BITS, default 3, number of set-index bits; sets = 2^INDEX_BITS.
REQ-002 Parameter OFFSET_BITS, default 3, word-offset bits within a line; line = 16*2^OFFSET_BITS bits (default 128).
REQ-003 Derived TAG_BITS = 15 - INDEX_BITS - OFFSET_BITS (default 9); address = {tag, index, word offset, byte bit}.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 mem_read, mem_write  in  1 each  CPU request strobes, held until mem_resp.
REQ-008 mem_address  in  16  CPU byte address.
REQ-009 mem_wdata  in  16  CPU write word.
REQ-010 mem_byte_enable  in  2  [1]=high byte, [0]=low byte.
REQ-011 mem_rdata  out  16  selected word of the line.
REQ-012 mem_resp  out  1  request complete.
REQ-013 pmem_read, pmem_write  out  1 each  line requests to memory.
REQ-014 pmem_address  out  16  line-aligned address, low OFFSET_BITS+1 bits zero.
REQ-015 pmem_wdata  out  line  victim line; pmem_rdata  in  line  fill data; pmem_resp  in  1  memory done.
REQ-016 hit_count, miss_count  out  16 each  performance counters.

Function
REQ-017 Storage: per set one valid bit, one dirty bit, one tag, one line; direct-mapped, write-back, write-allocate.
REQ-018 FSM states IDLE, WRITEBACK, FILL; no other states.
REQ-019 IDLE hit (request active, valid, tag match): mem_resp=1 combinationally in the same cycle; mem_rdata = addressed word.
REQ-020 Write hit: on that clock edge, write only bytes enabled by mem_byte_enable into addressed word; set dirty=1.
REQ-021 Both strobes active simultaneously: treated as write.
REQ-022 IDLE miss, victim valid and dirty: go to WRITEBACK; otherwise go to FILL.
REQ-023 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line, held until pmem_resp; on pmem_resp go to FILL.
REQ-024 FILL: pmem_read=1, pmem_address={request tag, index, 0}, held until pmem_resp; on pmem_resp load pmem_rdata, set tag, valid=1, dirty=0, go to IDLE.
REQ-025 After FILL the request is re-evaluated in IDLE as a hit (miss latency = memory cycles + 1); mem_resp never asserted outside IDLE.
REQ-026 pmem_read and pmem_write never asserted together; both 0 in IDLE.
REQ-027 hit_count increments once per completed request that hit on first IDLE evaluation; miss_count once per IDLE->WRITEBACK/FILL transition; both saturate at 0xFFFF, no wrap.
REQ-028 No request active in IDLE: no state change, mem_resp=0, counters unchanged.

Reset
REQ-029 reset asserted: state=IDLE, all valid=0, all dirty=0, hit_count=0, miss_count=0, immediately (asynchronous); data and tag arrays not reset.
REQ-030 Reset outputs: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0.
REQ-031 Reset mid-WRITEBACK or mid-FILL abandons the transfer; no partial line becomes valid.

Verification
REQ-032 After reset, read 0x1234 (index 3, tag 0x024, word 2) -> pmem_read, pmem_address=0x1230; pmem_resp with line word2=0xBEEF -> next cycle mem_resp=1, mem_rdata=0xBEEF, miss_count=1, hit_count=0.
REQ-033 Then write 0x1235, byte_enable=2'b10, wdata=0xAB00 -> same-cycle mem_resp; subsequent read 0x1234 returns 0xABEF, hit_count=2.
REQ-034 Then read 0x1A34 (index 3, tag 0x034) -> pmem_write at 0x1230 with word2=0xABEF, then pmem_read at 0x1A30, then mem_resp; pmem_read/pmem_write never overlap.
REQ-035 Reset asserted during FILL -> pmem_read falls without clock edge; read 0x1234 afterwards misses again.
REQ-036 INDEX_BITS=4, OFFSET_BITS=2 (64-bit line, TAG_BITS=9): read 0x00F6 -> pmem_address=0x00F0, data returned from word 3.
REQ-037 Force miss_count=0xFFFF, issue miss -> miss_count stays 0xFFFF.
